// File: rtl/clk_nco_bank.sv
//------------------------------------------------------------------------------
// Module   : clk_nco_bank
// Purpose  : Qualifies a raw PLL lock with a programmable stability delay and
//            drives NUM_CH independent phase-accumulator NCOs that produce
//            fractional-rate clock-enable ticks and square-wave outputs.
// Ports    : clock_in  - fabric clock, all logic on its rising edge
//            resetn    - synchronous reset, active-low
//            lock_in   - raw PLL lock, synchronous to clock_in
//            cfg_we    - config write strobe (one cycle per write)
//            cfg_ch    - target channel index
//            cfg_inc   - new phase increment
//            cfg_clr   - with cfg_we, also zero the target accumulator
//            locked    - qualified lock (registered)
//            tick      - per-channel one-cycle overflow strobe (registered)
//            phase_msb - per-channel accumulator MSB (~50% duty square wave)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clk_nco_bank #(
    parameter int          NUM_CH      = 4,
    parameter int          ACC_W       = 24,
    parameter int          LOCK_DELAY  = 1024,
    parameter int unsigned DEFAULT_INC = 0,
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock_in,
    input  logic              resetn,
    input  logic              lock_in,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              cfg_clr,
    output logic              locked,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] phase_msb
);

    localparam int CNT_W = $clog2(LOCK_DELAY + 1);

    localparam logic [1:0]       c_ST_UNLOCKED = 2'd0;
    localparam logic [1:0]       c_ST_QUALIFY  = 2'd1;
    localparam logic [1:0]       c_ST_RUN      = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_MAX     = CNT_W'(LOCK_DELAY);
    localparam logic [ACC_W-1:0] c_INC_RST     = ACC_W'(DEFAULT_INC);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_locked;
    logic             w_locked_nxt;
    logic             w_run_en;

    // State register
    always_ff @(posedge clock_in) begin
        if (!resetn) begin
            r_state  <= c_ST_UNLOCKED;
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_locked <= w_locked_nxt;
        end
    end

    // Next-state logic. The counter holds the number of consecutive high
    // samples of lock_in; the move to RUN happens on the edge after it
    // reaches LOCK_DELAY, giving LOCK_DELAY+1 edges from first high sample.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_UNLOCKED: begin
                if (lock_in) begin
                    w_state_nxt = c_ST_QUALIFY;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_QUALIFY: begin
                if (!lock_in) begin
                    w_state_nxt = c_ST_UNLOCKED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            c_ST_RUN: begin
                w_cnt_nxt = '0;
                if (!lock_in) begin
                    w_state_nxt = c_ST_UNLOCKED;
                end
            end
            default: begin
                w_state_nxt = c_ST_UNLOCKED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic. Accumulation only happens on edges that begin and end in
    // RUN: the entering edge leaves accumulators at zero (phase alignment)
    // and the leaving edge clears them, dropping any in-flight tick.
    always_comb begin
        w_locked_nxt = (w_state_nxt == c_ST_RUN);
        w_run_en     = (r_state == c_ST_RUN) && (w_state_nxt == c_ST_RUN);
    end

    assign locked = r_locked;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [CH_W-1:0] c_CH_IDX = CH_W'(g);

        logic [ACC_W-1:0] r_acc;
        logic [ACC_W-1:0] r_inc;
        logic             r_tick;
        logic [ACC_W:0]   w_sum;
        logic             w_wr;

        // Out-of-range cfg_ch values never match any channel index.
        assign w_wr  = cfg_we && (cfg_ch == c_CH_IDX);
        assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

        always_ff @(posedge clock_in) begin
            if (!resetn) begin
                r_acc  <= '0;
                r_inc  <= c_INC_RST;
                r_tick <= 1'b0;
            end else begin
                // Sum above uses the pre-write increment on the write edge.
                if (w_wr) begin
                    r_inc <= cfg_inc;
                end
                if (w_wr && cfg_clr) begin
                    r_acc  <= '0;
                    r_tick <= 1'b0;
                end else if (w_run_en) begin
                    r_acc  <= w_sum[ACC_W-1:0];
                    r_tick <= w_sum[ACC_W];
                end else begin
                    r_acc  <= '0;
                    r_tick <= 1'b0;
                end
            end
        end

        assign tick[g]      = r_tick;
        assign phase_msb[g] = r_acc[ACC_W-1];
    end

endmodule

`default_nettype wire
